// File: rtl/fpu_pipe.sv
// FP pipeline shell: FP register file, E1/E2/E3/WB stage registers and the
// div/sqrt occupancy sequencer. Optional stall counter under FPU_PERF_EN.
module fpu_pipe #(
    parameter int unsigned DIV_CYCLES = 4
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [4:0]  fs,
    input  logic [4:0]  ft,
    input  logic [4:0]  fd,
    input  logic [2:0]  fc,
    input  logic        wf,
    input  logic        fasmds,
    input  logic        fwdfa,
    input  logic        fwdfb,
    input  logic [4:0]  wrn,
    input  logic        wwfpr,
    input  logic [31:0] wmo,
    input  logic [31:0] fres,
    output logic [31:0] efa,
    output logic [31:0] efb,
    output logic [2:0]  e1c,
    output logic [2:0]  e2c,
    output logic [2:0]  e3c,
    output logic [4:0]  e1n,
    output logic [4:0]  e2n,
    output logic [4:0]  e3n,
    output logic        e1w,
    output logic        e2w,
    output logic        e3w,
    output logic [31:0] e3d,
    output logic [31:0] dfb,
    output logic        stall,
`ifdef FPU_PERF_EN
    output logic [31:0] perf_stall,
`endif
    output logic        st
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned NREGS  = 32;

    localparam logic [OP_W-1:0] OP_DIV  = OP_W'(3'b011);
    localparam logic [OP_W-1:0] OP_SQRT = OP_W'(3'b100);

    logic [DATA_W-1:0] rf [NREGS];

    logic [REG_W-1:0]  wb_n;
    logic              wb_w;
    logic [DATA_W-1:0] wb_d;

    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              st_d;

    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              issue_c;
    logic              issue_iter_c;

    assign e3d   = fres;
    assign stall = (cnt_q != '0);

    // Register-file reads with write-through; the FP result overrides lwc1.
    always_comb begin
        rd_a = rf[fs];
        rd_b = rf[ft];
        if (wwfpr && (wrn == fs)) rd_a = wmo;
        if (wwfpr && (wrn == ft)) rd_b = wmo;
        if (wb_w && (wb_n == fs)) rd_a = wb_d;
        if (wb_w && (wb_n == ft)) rd_b = wb_d;
        op_a = fwdfa ? fres : rd_a;
        op_b = fwdfb ? fres : rd_b;
    end

    assign dfb = op_b;

    assign issue_c      = fasmds && !stall;
    assign issue_iter_c = issue_c && ((fc == OP_DIV) || (fc == OP_SQRT));

    // Register file; the later assignment gives the FP result priority.
    always_ff @(posedge clock) begin
        if (wwfpr) rf[wrn] <= wmo;
        if (wb_w)  rf[wb_n] <= wb_d;
    end

    // Div/sqrt occupancy sequencer: next-state logic.
    always_comb begin
        cnt_d = cnt_q;
        st_d  = 1'b0;
        if (issue_iter_c) begin
            cnt_d = CNT_W'(DIV_CYCLES - 1);
            st_d  = 1'b1;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
            st    <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            st    <= st_d;
        end
    end

    // E1: load a new op or a bubble; held while the sequencer is busy.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            e1n <= '0;
            e1w <= 1'b0;
            e1c <= '0;
            efa <= '0;
            efb <= '0;
        end else if (!stall) begin
            if (fasmds) begin
                e1n <= fd;
                e1w <= wf;
                e1c <= fc;
                efa <= op_a;
                efb <= op_b;
            end else begin
                e1n <= '0;
                e1w <= 1'b0;
                e1c <= '0;
                efa <= '0;
                efb <= '0;
            end
        end
    end

    // E2 takes a bubble while E1 is held; E3 and WB always advance.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            e2n  <= '0;
            e2w  <= 1'b0;
            e2c  <= '0;
            e3n  <= '0;
            e3w  <= 1'b0;
            e3c  <= '0;
            wb_n <= '0;
            wb_w <= 1'b0;
            wb_d <= '0;
        end else begin
            if (stall) begin
                e2n <= '0;
                e2w <= 1'b0;
                e2c <= '0;
            end else begin
                e2n <= e1n;
                e2w <= e1w;
                e2c <= e1c;
            end
            e3n  <= e2n;
            e3w  <= e2w;
            e3c  <= e2c;
            wb_n <= e3n;
            wb_w <= e3w;
            wb_d <= fres;
        end
    end

`ifdef FPU_PERF_EN
    // Stall-cycle counter, wraps naturally at 2^32.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            perf_stall <= '0;
        end else if (stall) begin
            perf_stall <= perf_stall + 32'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fpu_pipe.sv
// Directed self-checking bench for fpu_pipe (DIV_CYCLES = 4).
module tb_fpu_pipe;

    logic        clock;
    logic        resetn;
    logic [4:0]  fs, ft, fd;
    logic [2:0]  fc;
    logic        wf, fasmds, fwdfa, fwdfb;
    logic [4:0]  wrn;
    logic        wwfpr;
    logic [31:0] wmo, fres;
    logic [31:0] efa, efb;
    logic [2:0]  e1c, e2c, e3c;
    logic [4:0]  e1n, e2n, e3n;
    logic        e1w, e2w, e3w;
    logic [31:0] e3d, dfb;
    logic        stall, st;
`ifdef FPU_PERF_EN
    logic [31:0] perf_stall;
`endif

    int errors = 0;
    int checks = 0;

    fpu_pipe #(.DIV_CYCLES(4)) dut (
        .clock(clock), .resetn(resetn),
        .fs(fs), .ft(ft), .fd(fd), .fc(fc),
        .wf(wf), .fasmds(fasmds), .fwdfa(fwdfa), .fwdfb(fwdfb),
        .wrn(wrn), .wwfpr(wwfpr), .wmo(wmo), .fres(fres),
        .efa(efa), .efb(efb),
        .e1c(e1c), .e2c(e2c), .e3c(e3c),
        .e1n(e1n), .e2n(e2n), .e3n(e3n),
        .e1w(e1w), .e2w(e2w), .e3w(e3w),
        .e3d(e3d), .dfb(dfb), .stall(stall),
`ifdef FPU_PERF_EN
        .perf_stall(perf_stall),
`endif
        .st(st)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        fs = '0; ft = '0; fd = '0; fc = '0;
        wf = 1'b0; fasmds = 1'b0; fwdfa = 1'b0; fwdfb = 1'b0;
        wrn = '0; wwfpr = 1'b0; wmo = '0;
    endtask

    task automatic lwc1(input logic [4:0] r, input logic [31:0] d);
        wwfpr = 1'b1; wrn = r; wmo = d;
        step();
        wwfpr = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [4:0] a,
                         input logic [4:0] b, input logic [4:0] dst);
        fasmds = 1'b1; wf = 1'b1; fc = op; fs = a; ft = b; fd = dst;
        step();
        fasmds = 1'b0; wf = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        fres = '0;
        resetn = 1'b0;
        #12;
        checks++; if ({e1w, e2w, e3w} !== 3'b000) begin errors++; $display("FAIL reset_ew got=%b exp=000", {e1w, e2w, e3w}); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if (st !== 1'b0) begin errors++; $display("FAIL reset_st got=%b exp=0", st); end
        checks++; if ({e1n, e2n, e3n} !== 15'd0) begin errors++; $display("FAIL reset_en got=%h exp=0", {e1n, e2n, e3n}); end
        step();
        resetn = 1'b1;
        step();
        checks++; if (e1w !== 1'b0 || e1c !== 3'd0) begin errors++; $display("FAIL bubble_e1 got w=%b c=%0d exp w=0 c=0", e1w, e1c); end
    endtask

    task automatic test_add_pipe();
        lwc1(5'd1, 32'h3F80_0000);
        fres = 32'h4000_0000;
        issue(3'b000, 5'd1, 5'd1, 5'd3);
        checks++; if (e1w !== 1'b1 || e1n !== 5'd3) begin errors++; $display("FAIL add_e1 got w=%b n=%0d exp w=1 n=3", e1w, e1n); end
        checks++; if (efa !== 32'h3F80_0000 || efb !== 32'h3F80_0000) begin errors++; $display("FAIL add_ops got a=%h b=%h exp 3f800000", efa, efb); end
        step();
        checks++; if (e2w !== 1'b1 || e1w !== 1'b0 || e2n !== 5'd3) begin errors++; $display("FAIL add_e2 got e1w=%b e2w=%b n=%0d exp 0 1 3", e1w, e2w, e2n); end
        step();
        checks++; if (e3w !== 1'b1 || e3n !== 5'd3 || e3c !== 3'd0) begin errors++; $display("FAIL add_e3 got w=%b n=%0d c=%0d exp 1 3 0", e3w, e3n, e3c); end
        checks++; if (e3d !== 32'h4000_0000) begin errors++; $display("FAIL add_e3d got=%h exp=40000000", e3d); end
        step();
        step();
        ft = 5'd3;
        #1;
        checks++; if (dfb !== 32'h4000_0000) begin errors++; $display("FAIL add_f3 got=%h exp=40000000", dfb); end
        // write-through on the lwc1 port
        ft = 5'd4; wwfpr = 1'b1; wrn = 5'd4; wmo = 32'h1111_1111;
        #1;
        checks++; if (dfb !== 32'h1111_1111) begin errors++; $display("FAIL wthru_lwc1 got=%h exp=11111111", dfb); end
        step();
        wwfpr = 1'b0;
    endtask

    task automatic test_forwarding();
        fres = 32'h1234_5678; ft = 5'd3; fwdfb = 1'b1;
        #1;
        checks++; if (dfb !== 32'h1234_5678) begin errors++; $display("FAIL fwd_dfb got=%h exp=12345678", dfb); end
        fwdfb = 1'b0; fwdfa = 1'b1;
        issue(3'b000, 5'd9, 5'd1, 5'd8);
        fwdfa = 1'b0;
        checks++; if (efa !== 32'h1234_5678 || efb !== 32'h3F80_0000) begin errors++; $display("FAIL fwd_efa got a=%h b=%h exp 12345678 3f800000", efa, efb); end
        repeat (5) step();
    endtask

    task automatic test_div();
        lwc1(5'd5, 32'h0);
        fres = 32'hC0DE_0000;
        issue(3'b011, 5'd1, 5'd1, 5'd5);
        checks++; if (st !== 1'b1 || stall !== 1'b1) begin errors++; $display("FAIL div_start got st=%b stall=%b exp 1 1", st, stall); end
        checks++; if (e1w !== 1'b1 || e1c !== 3'b011) begin errors++; $display("FAIL div_e1 got w=%b c=%0d exp 1 3", e1w, e1c); end
        step();
        checks++; if (st !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL div_hold1 got st=%b stall=%b exp 0 1", st, stall); end
        checks++; if (e2w !== 1'b0 || e1w !== 1'b1 || e1n !== 5'd5) begin errors++; $display("FAIL div_hold1_stage got e2w=%b e1w=%b e1n=%0d exp 0 1 5", e2w, e1w, e1n); end
        step();
        checks++; if (stall !== 1'b1 || e2w !== 1'b0) begin errors++; $display("FAIL div_hold2 got stall=%b e2w=%b exp 1 0", stall, e2w); end
        step();
        checks++; if (stall !== 1'b0 || e2w !== 1'b0 || e1w !== 1'b1) begin errors++; $display("FAIL div_release got stall=%b e2w=%b e1w=%b exp 0 0 1", stall, e2w, e1w); end
        step();
        checks++; if (e2w !== 1'b1 || e2n !== 5'd5 || e1w !== 1'b0) begin errors++; $display("FAIL div_e2 got e2w=%b e2n=%0d e1w=%b exp 1 5 0", e2w, e2n, e1w); end
        step();
        ft = 5'd5;
        #1;
        checks++; if (dfb !== 32'h0) begin errors++; $display("FAIL div_early got=%h exp=00000000", dfb); end
        step();
        step();
        checks++; if (dfb !== 32'hC0DE_0000) begin errors++; $display("FAIL div_f5 got=%h exp=c0de0000", dfb); end
    endtask

    task automatic test_write_conflict();
        fres = 32'hAAAA_0000;
        issue(3'b000, 5'd1, 5'd1, 5'd2);
        repeat (3) step();
        wwfpr = 1'b1; wrn = 5'd2; wmo = 32'h5555_0000; ft = 5'd2;
        #1;
        checks++; if (dfb !== 32'hAAAA_0000) begin errors++; $display("FAIL conflict_wthru got=%h exp=aaaa0000", dfb); end
        step();
        wwfpr = 1'b0;
        #1;
        checks++; if (dfb !== 32'hAAAA_0000) begin errors++; $display("FAIL conflict_f2 got=%h exp=aaaa0000", dfb); end
    endtask

    task automatic test_back_to_back();
        fres = 32'h0B0B_0000;
        fasmds = 1'b1; wf = 1'b1; fc = 3'b011; fs = 5'd1; ft = 5'd1; fd = 5'd6;
        step();
        checks++; if (st !== 1'b1 || e1n !== 5'd6) begin errors++; $display("FAIL b2b_first got st=%b e1n=%0d exp 1 6", st, e1n); end
        fd = 5'd7;
        step();
        checks++; if (st !== 1'b0 || e1n !== 5'd6) begin errors++; $display("FAIL b2b_ignore got st=%b e1n=%0d exp 0 6", st, e1n); end
        step();
        step();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_gap got stall=%b exp=0", stall); end
        step();
        fasmds = 1'b0; wf = 1'b0;
        checks++; if (st !== 1'b1 || stall !== 1'b1 || e1n !== 5'd7) begin errors++; $display("FAIL b2b_second got st=%b stall=%b e1n=%0d exp 1 1 7", st, stall, e1n); end
        checks++; if (e2w !== 1'b1 || e2n !== 5'd6) begin errors++; $display("FAIL b2b_e2 got e2w=%b e2n=%0d exp 1 6", e2w, e2n); end
        repeat (10) step();
    endtask

    task automatic test_reset_mid_div();
        lwc1(5'd5, 32'hDEAD_BEEF);
        fres = 32'h9999_9999;
        issue(3'b011, 5'd1, 5'd1, 5'd5);
        step();
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rmid_pre got stall=%b exp=1", stall); end
        resetn = 1'b0;
        #1;
        checks++; if (stall !== 1'b0 || st !== 1'b0) begin errors++; $display("FAIL rmid_async got stall=%b st=%b exp 0 0", stall, st); end
        checks++; if (e1w !== 1'b0 || e1n !== 5'd0) begin errors++; $display("FAIL rmid_e1 got w=%b n=%0d exp 0 0", e1w, e1n); end
        step();
        step();
        resetn = 1'b1;
        repeat (8) step();
        ft = 5'd5;
        #1;
        checks++; if (dfb !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rmid_f5 got=%h exp=deadbeef", dfb); end
        checks++; if ({e1w, e2w, e3w} !== 3'b000) begin errors++; $display("FAIL rmid_ew got=%b exp=000", {e1w, e2w, e3w}); end
    endtask

    initial begin
        test_reset();
        test_add_pipe();
        test_forwarding();
        test_div();
        test_write_conflict();
        test_back_to_back();
        test_reset_mid_div();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
